// File: rtl/ram_64_pkg.sv
// Shared definitions for the ram_64 register-array memory.
// Holds the common data width and the RAM geometry constants.
package ram_64_pkg;

  localparam int RAM_DATA_WIDTH = 32;
  localparam int RAM_DEPTH      = 64;
  localparam int RAM_ADDR_BITS  = 6;

endpackage : ram_64_pkg

// File: rtl/ram_64.sv
// Single-port-address register-array RAM with one-cycle registered read.
// Define RAM_64_WRITE_FIRST_EN for write-first collision behaviour (default: read-first).
module ram_64
  import ram_64_pkg::*;
#(
  parameter int DATA_WIDTH = RAM_DATA_WIDTH,
  parameter int DEPTH      = RAM_DEPTH,
  parameter int ADDR_BITS  = RAM_ADDR_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  write_en,
  input  logic                  read_en,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] data_out_r;
  logic [DATA_WIDTH-1:0] rd_data_s;
  logic [ADDR_BITS-1:0]  idx_s;
  logic                  in_range_s;
  logic                  collision_s;
  logic                  do_write_s;

  assign idx_s = address[ADDR_BITS-1:0];

  // Decode address range and same-edge read/write collision.
  always_comb begin
    in_range_s  = 1'b0;
    collision_s = 1'b0;
    do_write_s  = 1'b0;
    if (address[DATA_WIDTH-1:ADDR_BITS] == {(DATA_WIDTH-ADDR_BITS){1'b0}}) begin
      in_range_s  = 1'b1;
      collision_s = write_en & read_en;
      do_write_s  = write_en;
    end else begin
      in_range_s  = 1'b0;
      collision_s = 1'b0;
      do_write_s  = 1'b0;
    end
  end

  // Select the word the read port will capture; out-of-range reads return zero.
  always_comb begin
    rd_data_s = {DATA_WIDTH{1'b0}};
    if (!in_range_s) begin
      rd_data_s = {DATA_WIDTH{1'b0}};
    end else if (collision_s) begin
`ifdef RAM_64_WRITE_FIRST_EN
      rd_data_s = data_in;
`else
      rd_data_s = mem_r[idx_s];
`endif
    end else begin
      rd_data_s = mem_r[idx_s];
    end
  end

  // Storage and read register; reset clears everything and overrides both enables.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
      data_out_r <= {DATA_WIDTH{1'b0}};
    end else begin
      if (do_write_s) begin
        mem_r[idx_s] <= data_in;
      end
      if (read_en) begin
        data_out_r <= rd_data_s;
      end
    end
  end

  assign data_out = data_out_r;

endmodule : ram_64

// File: tb/tb_ram_64.sv
// Scoreboard bench for ram_64: driver pushes expected data_out per cycle, monitor checks.
module tb_ram_64;

  logic        clk;
  logic        rst;
  logic [31:0] address;
  logic [31:0] data_in;
  logic        write_en;
  logic        read_en;
  logic [31:0] data_out;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model_mem [64];
  logic [31:0] model_dout;
  int          tests;
  int          fails;
  bit          done;

  ram_64 dut (
    .clk      (clk),
    .rst      (rst),
    .address  (address),
    .data_in  (data_in),
    .write_en (write_en),
    .read_en  (read_en),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of stimulus and predict data_out after the next rising edge.
  task automatic issue(input string tag, input logic r, input logic we, input logic re,
                       input logic [31:0] a, input logic [31:0] d);
    bit in_range;
    @(negedge clk);
    rst      = r;
    write_en = we;
    read_en  = re;
    address  = a;
    data_in  = d;
    in_range = (a < 32'd64);
    if (r) begin
      for (int i = 0; i < 64; i++) model_mem[i] = 32'h0;
      model_dout = 32'h0;
    end else begin
      if (re) begin
        if (!in_range) model_dout = 32'h0;
`ifdef RAM_64_WRITE_FIRST_EN
        else if (we) model_dout = d;
`endif
        else model_dout = model_mem[a];
      end
      if (we && in_range) model_mem[a] = d;
    end
    sb_q.push_back('{tag: tag, exp: model_dout});
  endtask

  // Monitor: compare data_out just after each edge that had predicted stimulus.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        tests++;
        if (data_out !== e.exp) begin
          fails++;
          $display("FAIL %s: data_out=%h expected=%h", e.tag, data_out, e.exp);
        end
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic        we;
    logic        re;
    logic        r;
    int          sel;
    int          waited;
    tests = 0;
    fails = 0;
    rst = 1'b1; write_en = 1'b0; read_en = 1'b0; address = 32'h0; data_in = 32'h0;
    for (int i = 0; i < 64; i++) model_mem[i] = 32'h0;
    model_dout = 32'h0;

    issue("reset",        1'b1, 1'b0, 1'b0, 32'd0,  32'h0);
    issue("rd20_after_rst", 1'b0, 1'b0, 1'b1, 32'd20, 32'h0);
    issue("wr10",         1'b0, 1'b1, 1'b0, 32'd10, 32'hDEADBEEF);
    issue("rd10",         1'b0, 1'b0, 1'b1, 32'd10, 32'h0);
    issue("wr30",         1'b0, 1'b1, 1'b0, 32'd30, 32'hCAFEBABE);
    issue("rd30",         1'b0, 1'b0, 1'b1, 32'd30, 32'h0);
    issue("rd10_again",   1'b0, 1'b0, 1'b1, 32'd10, 32'h0);
    issue("hold_idle",    1'b0, 1'b0, 1'b0, 32'd30, 32'h0);
    issue("wr64_oor",     1'b0, 1'b1, 1'b0, 32'd64, 32'h12345678);
    issue("rd64_oor",     1'b0, 1'b0, 1'b1, 32'd64, 32'h0);
    issue("rd0_noalias",  1'b0, 1'b0, 1'b1, 32'd0,  32'h0);
    issue("wr5",          1'b0, 1'b1, 1'b0, 32'd5,  32'h11111111);
    issue("collide5",     1'b0, 1'b1, 1'b1, 32'd5,  32'h22222222);
    issue("rd5_after",    1'b0, 1'b0, 1'b1, 32'd5,  32'h0);
    issue("wr63",         1'b0, 1'b1, 1'b0, 32'd63, 32'hA5A5A5A5);
    issue("rd63",         1'b0, 1'b0, 1'b1, 32'd63, 32'h0);
    issue("rst_with_wr1", 1'b1, 1'b1, 1'b1, 32'd1,  32'h77777777);
    issue("rd63_cleared", 1'b0, 1'b0, 1'b1, 32'd63, 32'h0);
    issue("rd1_discarded", 1'b0, 1'b0, 1'b1, 32'd1, 32'h0);
    issue("wr_hi_oor",    1'b0, 1'b1, 1'b1, 32'h8000_0003, 32'hFFFF0000);
    issue("rd3_noalias",  1'b0, 1'b0, 1'b1, 32'd3,  32'h0);

    for (int n = 0; n < 1500; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 8)       a = 32'($urandom_range(0, 63));
      else if (sel == 8) a = 32'd64 + 32'($urandom_range(0, 7));
      else               a = $urandom;
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) begin
        we = 1'b1;
        re = 1'b1;
      end
      r = ($urandom_range(0, 99) == 0);
      issue("random", r, we, re, a, $urandom);
    end

    @(negedge clk);
    write_en = 1'b0;
    read_en  = 1'b0;
    rst      = 1'b0;
    waited = 0;
    while (sb_q.size() > 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (sb_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: pending=%0d expected=0", sb_q.size());
    end
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_ram_64

// File: doc/ram_64.md
RAM_64 -- requirements
Module: ram_64

Interface
REQ-001 Parameter DATA_WIDTH, default 32 (shared definition), word and address port width.
REQ-002 Parameter DEPTH, default 64, number of stored words.
REQ-003 Parameter ADDR_BITS, default 6, index bits used (log2 DEPTH).
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 address  input  DATA_WIDTH  word address.
REQ-007 data_in  input  DATA_WIDTH  write data.
REQ-008 write_en  input  1  write request, sampled on rising clk.
REQ-009 read_en  input  1  read request, sampled on rising clk.
REQ-010 data_out  output  DATA_WIDTH  registered read data.

Function
REQ-011 Storage SHALL be DEPTH words of DATA_WIDTH bits, indexed by address[ADDR_BITS-1:0].
REQ-012 Write: at rising clk with rst=0, write_en=1 and address in range, mem[address] SHALL take data_in, visible to reads from the next edge.
REQ-013 Read: at rising clk with rst=0, read_en=1, data_out SHALL load mem[address]; read latency is exactly one clock edge.
REQ-014 With read_en=0, data_out SHALL hold its previous value.
REQ-015 Address in range means address[DATA_WIDTH-1:ADDR_BITS]==0; out-of-range writes SHALL be ignored and out-of-range reads SHALL load 0 into data_out.
REQ-016 Never-written locations SHALL read 0 after reset.
REQ-017 Simultaneous write_en=1 and read_en=1 to the same in-range address SHALL follow REQ-026/REQ-027; to different addresses both operations SHALL complete in the same edge.
REQ-018 Both enables 0: memory and data_out SHALL be unchanged.
REQ-019 Address 63 is the last valid word; address 64 SHALL be out of range (no wrap-around).

Reset
REQ-020 At rising clk with rst=1, all DEPTH words SHALL clear to 0 and data_out SHALL clear to 0.
REQ-021 rst SHALL have priority over write_en and read_en in the same edge; a write coincident with reset is discarded.
REQ-022 Reset asserted mid-sequence SHALL discard prior contents; operation resumes on the first edge with rst=0.

Configuration
REQ-023 Macro RAM_64_WRITE_FIRST_EN SHALL select same-address read/write collision behaviour.
REQ-024 Macro affects only data_out during a same-address simultaneous read/write; all other behaviour is identical.
REQ-025 Collision is defined as write_en=1, read_en=1, identical in-range address, same edge.
REQ-026 With RAM_64_WRITE_FIRST_EN defined: on collision data_out SHALL load data_in (write-first bypass).
REQ-027 Without it: on collision data_out SHALL load the old mem contents (read-first); the write still completes.

Structure
REQ-028 DATA_WIDTH SHALL come from the shared definitions header; RAM_DEPTH (64) and RAM_ADDR_BITS (6) constants SHALL be added there.
REQ-029 Implementation SHALL be a single module with no sub-modules; storage is a register array.

Verification
REQ-030 rst=1 one edge, then read address 20 -> data_out=32'h00000000 one edge later.
REQ-031 Write address 10, data 32'hDEADBEEF; next cycle read address 10 -> data_out=32'hDEADBEEF after one edge.
REQ-032 Write address 30, data 32'hCAFEBABE, then read 30 -> 32'hCAFEBABE; address 10 still returns 32'hDEADBEEF.
REQ-033 Write address 64, data 32'h12345678, then read 64 -> 0 and read 0 -> 0 (no alias).
REQ-034 mem[5]=32'h11111111; same edge write 32'h22222222 and read address 5 -> data_out=32'h22222222 with RAM_64_WRITE_FIRST_EN, 32'h11111111 without; next read returns 32'h22222222 in both builds.
REQ-035 Write address 63 data 32'hA5A5A5A5, assert rst with write_en=1 at address 1, then read 63 and 1 -> both 0.
